cmp_seq_ctrl: RTL

//  Controller for a shared registered 1-bit comparator (inputs a/b, outputs gt/ls/eq).

---
 rtl/cmp_seq_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cmp_seq_ctrl.sv
// Bit-serial MSB-first compare controller driving a shared registered 1-bit comparator.
// Optional macro CMP_SEQ_EARLY_EXIT_EN finishes on the first decisive gt/ls result.
module cmp_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             ls,
    output logic             eq,
    output logic             err,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_gt,
    input  logic             cmp_ls,
    input  logic             cmp_eq
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sh_a, sh_b;
    logic [CW-1:0]      lcnt, scnt;
    logic [CMP_LAT-1:0] tag_p, tag_nxt;
    logic               fnd_gt, fnd_ls, fnd_err;
    logic               fin_gt, fin_ls, fin_err;
    logic               accept, launch, smp_vld, onehot, take, early, complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        launch    = 1'b0;
        smp_vld   = 1'b0;
        early     = 1'b0;
        complete  = 1'b0;
        onehot    = ({cmp_gt, cmp_ls, cmp_eq} == 3'b100) ||
                    ({cmp_gt, cmp_ls, cmp_eq} == 3'b010) ||
                    ({cmp_gt, cmp_ls, cmp_eq} == 3'b001);
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                smp_vld = tag_p[CMP_LAT-1];
                launch  = (lcnt < CW'(WIDTH));
            end
            default: state_nxt = IDLE;
        endcase
        // Only the first one-hot decisive sample may set the verdict
        take    = smp_vld && onehot && !fnd_gt && !fnd_ls;
        fin_gt  = fnd_gt | (take & cmp_gt);
        fin_ls  = fnd_ls | (take & cmp_ls);
        fin_err = fnd_err | (smp_vld & ~onehot);
`ifdef CMP_SEQ_EARLY_EXIT_EN
        early   = take && !cmp_eq && !fnd_err;
`else
        early   = 1'b0;
`endif
        complete = smp_vld && ((scnt == CW'(WIDTH - 1)) || early);
        if (complete) begin
            launch    = 1'b0;
            state_nxt = IDLE;
        end
        // Flushing the tag pipe on completion keeps stale comparator results untagged
        tag_nxt    = tag_p << 1;
        tag_nxt[0] = accept | launch;
        if (complete) tag_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_a    <= '0;
            sh_b    <= '0;
            lcnt    <= '0;
            scnt    <= '0;
            tag_p   <= '0;
            fnd_gt  <= 1'b0;
            fnd_ls  <= 1'b0;
            fnd_err <= 1'b0;
            cmp_a   <= 1'b0;
            cmp_b   <= 1'b0;
            done    <= 1'b0;
            gt      <= 1'b0;
            ls      <= 1'b0;
            eq      <= 1'b0;
            err     <= 1'b0;
        end else begin
            tag_p <= tag_nxt;
            done  <= complete;
            if (accept) begin
                sh_a    <= a_in << 1;
                sh_b    <= b_in << 1;
                cmp_a   <= a_in[WIDTH-1];
                cmp_b   <= b_in[WIDTH-1];
                lcnt    <= CW'(1);
                scnt    <= '0;
                fnd_gt  <= 1'b0;
                fnd_ls  <= 1'b0;
                fnd_err <= 1'b0;
                gt      <= 1'b0;
                ls      <= 1'b0;
                eq      <= 1'b0;
                err     <= 1'b0;
            end else if (launch) begin
                sh_a  <= sh_a << 1;
                sh_b  <= sh_b << 1;
                cmp_a <= sh_a[WIDTH-1];
                cmp_b <= sh_b[WIDTH-1];
                lcnt  <= lcnt + 1'b1;
            end else begin
                cmp_a <= 1'b0;
                cmp_b <= 1'b0;
            end
            if (smp_vld) begin
                scnt    <= scnt + 1'b1;
                fnd_gt  <= fin_gt;
                fnd_ls  <= fin_ls;
                fnd_err <= fin_err;
            end
            if (complete) begin
                gt  <= fin_gt & ~fin_err;
                ls  <= fin_ls & ~fin_err;
                eq  <= ~fin_gt & ~fin_ls & ~fin_err;
                err <= fin_err;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
